// File: rtl/alu_arbiter_pkg.sv
// Shared ALU function codes and requester sizing for the two-port ALU arbiter.
package alu_arbiter_pkg;

  localparam int REQ_W = 2;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;

  function automatic logic is_arith(input logic [5:0] fun);
    return fun[5:4] == 2'b00;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, one consumer and the arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [REQ_W-1:0] req_valid;
  logic [REQ_W-1:0] req_ready;
  logic [31:0]      req0_A;
  logic [31:0]      req0_B;
  logic [31:0]      req1_A;
  logic [31:0]      req1_B;
  logic [5:0]       req0_ALUFun;
  logic [5:0]       req1_ALUFun;
  logic             req0_Sign;
  logic             req1_Sign;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_Z;
  logic             rsp_V;
  logic [REQ_W-1:0] ovf_sticky;
  logic [REQ_W-1:0] ovf_clear;

  modport master (
    output req_valid, req0_A, req0_B, req1_A, req1_B, req0_ALUFun, req1_ALUFun,
           req0_Sign, req1_Sign, rsp_ready, ovf_clear,
    input  req_ready, rsp_valid, rsp_id, rsp_Z, rsp_V, ovf_sticky
  );

  modport slave (
    input  req_valid, req0_A, req0_B, req1_A, req1_B, req0_ALUFun, req1_ALUFun,
           req0_Sign, req1_Sign, rsp_ready, ovf_clear,
    output req_ready, rsp_valid, rsp_id, rsp_Z, rsp_V, ovf_sticky
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: arith, logic, shift (B shifted by A[4:0]) and compare.
// V always reflects the adder/subtractor, whatever function is selected.
module alu_arbiter_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [5:0]  alufun_i,
  input  logic        sign_i,
  output logic [31:0] z_o,
  output logic        v_o
);

  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf_signed;
  logic        ovf_unsigned;
  logic        lt;
  logic [4:0]  shamt;

  always_comb begin
    b_eff        = alufun_i[0] ? ~b_i : b_i;
    sum          = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, alufun_i[0]};
    ovf_signed   = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
    // Unsigned add overflows on carry-out, unsigned subtract on borrow.
    ovf_unsigned = sum[32] ^ alufun_i[0];
    v_o          = sign_i ? ovf_signed : ovf_unsigned;
    lt           = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    shamt        = a_i[4:0];
    z_o          = 32'd0;
    case (alufun_i[5:4])
      2'b00: z_o = sum[31:0];
      2'b01: begin
        case (alufun_i[3:0])
          4'b1000: z_o = a_i & b_i;
          4'b1110: z_o = a_i | b_i;
          4'b0110: z_o = a_i ^ b_i;
          4'b0001: z_o = ~(a_i | b_i);
          4'b1010: z_o = a_i;
          default: z_o = 32'd0;
        endcase
      end
      2'b10: begin
        case (alufun_i[1:0])
          2'b01:   z_o = b_i >> shamt;
          2'b11:   z_o = $signed(b_i) >>> shamt;
          default: z_o = b_i << shamt;
        endcase
      end
      default: begin
        case (alufun_i[3:1])
          3'b001:  z_o = {31'd0, a_i == b_i};
          3'b000:  z_o = {31'd0, a_i != b_i};
          3'b010:  z_o = {31'd0, lt};
          default: z_o = 32'd0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, 1-cycle registered result.
// A grant happens only when the result slot is empty or draining this cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  if (N_REQ != REQ_W) begin : g_bad_n_req
    $error("alu_arbiter supports exactly two requesters");
  end

  logic             last_q, last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_z_q, rsp_z_d;
  logic             rsp_v_q, rsp_v_d;
  logic             rsp_id_q, rsp_id_d;
  logic [REQ_W-1:0] ovf_q, ovf_d;

  logic             slot_free;
  logic [REQ_W-1:0] grant;
  logic             gnt_id;
  logic [31:0]      sel_a, sel_b;
  logic [5:0]       sel_fun;
  logic             sel_sign;
  logic [31:0]      alu_z;
  logic             alu_v;
  logic [REQ_W-1:0] ovf_set;

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  always_comb begin
    grant = '0;
    if (!reset && slot_free) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Under contention the requester that did not win last time goes first.
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_id   = grant[1];
  assign sel_a    = gnt_id ? bus.req1_A      : bus.req0_A;
  assign sel_b    = gnt_id ? bus.req1_B      : bus.req0_B;
  assign sel_fun  = gnt_id ? bus.req1_ALUFun : bus.req0_ALUFun;
  assign sel_sign = gnt_id ? bus.req1_Sign   : bus.req0_Sign;

  alu_arbiter_alu u_alu (
    .a_i      (sel_a),
    .b_i      (sel_b),
    .alufun_i (sel_fun),
    .sign_i   (sel_sign),
    .z_o      (alu_z),
    .v_o      (alu_v)
  );

  assign ovf_set = grant & {REQ_W{is_arith(sel_fun) && sel_sign && alu_v}};

  always_comb begin
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_v_d     = rsp_v_q;
    rsp_id_d    = rsp_id_q;
    if (|grant) begin
      last_d      = gnt_id;
      rsp_valid_d = 1'b1;
      rsp_z_d     = alu_z;
      rsp_v_d     = alu_v;
      rsp_id_d    = gnt_id;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    // A new overflow in the same cycle as a clear must survive.
    ovf_d = (ovf_q & ~bus.ovf_clear) | ovf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= 32'd0;
      rsp_v_q     <= 1'b0;
      rsp_id_q    <= 1'b0;
      ovf_q       <= '0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_v_q     <= rsp_v_d;
      rsp_id_q    <= rsp_id_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_Z      = rsp_z_q;
  assign bus.rsp_V      = rsp_v_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected results queued at grant, checked when consumed.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct packed {
    logic        id;
    logic        v;
    logic [31:0] z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  alu_arbiter_if bus();

  alu_arbiter #(.N_REQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req0_ALUFun = f; bus.req0_A = a; bus.req0_B = b; bus.req0_Sign = s;
  endtask

  task automatic set_req1(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req1_ALUFun = f; bus.req1_A = a; bus.req1_B = b; bus.req1_Sign = s;
  endtask

  // Checks the grant for the current cycle, queues its result, and advances one edge.
  task automatic issue(input string name, input logic [1:0] exp_g, input logic id,
                       input logic [31:0] z, input logic v);
    exp_t e;
    #1;
    check(name, {30'd0, bus.req_ready}, {30'd0, exp_g});
    if (exp_g != 2'b00) begin
      e.id = id; e.v = v; e.z = z;
      sb_q.push_back(e);
    end
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d Z=0x%08h with nothing expected", bus.rsp_id, bus.rsp_Z);
      end else begin
        e = sb_q.pop_front();
        check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
        check("rsp_Z",  bus.rsp_Z, e.z);
        check("rsp_V",  {31'd0, bus.rsp_V}, {31'd0, e.v});
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    bus.ovf_clear = 2'b00;
    set_req0(ALU_ADD, 32'd1, 32'd2, 1'b1);
    set_req1(ALU_SUB, 32'd10, 32'd3, 1'b0);
    tick();
    check("reset_req_ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_Z", bus.rsp_Z, 32'd0);
    check("reset_rsp_V", {31'd0, bus.rsp_V}, 32'd0);
    check("reset_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    check("reset_ovf", {30'd0, bus.ovf_sticky}, 32'd0);

    // Contention right after reset alternates 0,1,0,1.
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) issue("rr_grant", 2'b01, 1'b0, 32'd3, 1'b0);
      else            issue("rr_grant", 2'b10, 1'b1, 32'd7, 1'b0);
    end
    bus.req_valid = 2'b00;

    set_req0(ALU_ADD, 32'd5, 32'd7, 1'b1);
    bus.req_valid = 2'b01;
    issue("add_grant", 2'b01, 1'b0, 32'd12, 1'b0);
    bus.req_valid = 2'b00;
    check("add_latency", {31'd0, bus.rsp_valid}, 32'd1);

    set_req1(ALU_SUB, 32'h8000_0000, 32'd1, 1'b1);
    bus.req_valid = 2'b10;
    issue("sub_ovf_grant", 2'b10, 1'b1, 32'h7FFF_FFFF, 1'b1);
    bus.req_valid = 2'b00;
    check("ovf_set", {30'd0, bus.ovf_sticky}, 32'd2);
    bus.ovf_clear = 2'b10;
    tick();
    bus.ovf_clear = 2'b00;
    check("ovf_clear", {30'd0, bus.ovf_sticky}, 32'd0);

    bus.req_valid = 2'b10;
    bus.ovf_clear = 2'b10;
    issue("set_vs_clear_grant", 2'b10, 1'b1, 32'h7FFF_FFFF, 1'b1);
    bus.req_valid = 2'b00;
    bus.ovf_clear = 2'b00;
    check("set_wins", {30'd0, bus.ovf_sticky}, 32'd2);
    bus.ovf_clear = 2'b10;
    tick();
    bus.ovf_clear = 2'b00;

    // Non-arithmetic ops still report V but never set the sticky bits.
    set_req0(ALU_XOR, 32'h7FFF_FFFF, 32'd1, 1'b1);
    bus.req_valid = 2'b01;
    issue("xor_grant", 2'b01, 1'b0, 32'h7FFF_FFFE, 1'b1);
    set_req1(ALU_SRA, 32'd4, 32'h8000_0000, 1'b1);
    bus.req_valid = 2'b10;
    issue("sra_grant", 2'b10, 1'b1, 32'hF800_0000, 1'b1);
    set_req1(ALU_LT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue("lt_grant", 2'b10, 1'b1, 32'd1, 1'b0);
    bus.req_valid = 2'b00;
    check("ovf_nonarith", {30'd0, bus.ovf_sticky}, 32'd0);

    set_req0(ALU_SLL, 32'd4, 32'd1, 1'b0);
    bus.req_valid = 2'b01;
    issue("sll_grant", 2'b01, 1'b0, 32'd16, 1'b0);
    bus.rsp_ready = 1'b0;
    set_req0(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_req_ready", {30'd0, bus.req_ready}, 32'd0);
      check("hold_rsp_Z", bus.rsp_Z, 32'd16);
      check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    issue("drain_and_grant", 2'b01, 1'b0, 32'h0000_F000, 1'b0);
    bus.req_valid = 2'b00;

    set_req0(ALU_ADD, 32'd1, 32'd1, 1'b1);
    bus.req_valid = 2'b01;
    issue("pre_reset_grant", 2'b01, 1'b0, 32'd2, 1'b0);
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("inreset_req_ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    check("reset_discard_valid", {31'd0, bus.rsp_valid}, 32'd0);
    bus.rsp_ready = 1'b1;
    issue("post_reset_contention", 2'b01, 1'b0, 32'd2, 1'b0);
    bus.req_valid = 2'b00;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("scoreboard_empty", sb_q.size(), 32'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, meaning the number of requesters; only 2 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have ports req_valid, input, 2 bits, meaning per-requester operation valid.
REQ-005 The block SHALL have ports req_ready, output, 2 bits, meaning per-requester operation accepted this cycle.
REQ-006 The block SHALL have ports req0_A, req0_B, req1_A, req1_B, input, 32 bits each, meaning operands.
REQ-007 The block SHALL have ports req0_ALUFun, req1_ALUFun, input, 6 bits each, meaning ALU function code.
REQ-008 The block SHALL have ports req0_Sign, req1_Sign, input, 1 bit each, meaning signed operation.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit, meaning result held.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit, meaning consumer takes result.
REQ-011 The block SHALL have port rsp_id, output, 1 bit, meaning requester index that owns the result.
REQ-012 The block SHALL have port rsp_Z, output, 32 bits, meaning ALU result.
REQ-013 The block SHALL have port rsp_V, output, 1 bit, meaning ALU overflow flag for the result.
REQ-014 The block SHALL have port ovf_sticky, output, 2 bits, meaning per-requester overflow seen on a signed ADD/SUB.
REQ-015 The block SHALL have port ovf_clear, input, 2 bits, meaning clear the matching ovf_sticky bit.

Function
REQ-016 The block SHALL instantiate exactly one combinational ALU and feed it the operands, ALUFun and Sign of the granted requester.
REQ-017 The output slot SHALL be free when rsp_valid=0 or (rsp_valid=1 and rsp_ready=1) in the same cycle.
REQ-018 A grant SHALL occur only when the slot is free and at least one req_valid bit is 1; at most one req_ready bit SHALL be 1 per cycle.
REQ-019 req_ready[i] SHALL be combinational: 1 iff requester i is granted this cycle.
REQ-020 When both requesters are valid, the grant SHALL go to the requester not granted last (round-robin); a single valid requester SHALL be granted regardless of the pointer.
REQ-021 The last-grant pointer SHALL update only on a grant.
REQ-022 On a grant, rsp_Z, rsp_V and rsp_id SHALL be registered and rsp_valid set at the next edge; latency is exactly 1 cycle, and back-to-back grants SHALL sustain 1 op/cycle while rsp_ready=1.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_Z, rsp_V and rsp_id SHALL hold stable and req_ready SHALL be 00.
REQ-024 If the slot drains with no grant in the same cycle, rsp_valid SHALL go 0 at the next edge.
REQ-025 ovf_sticky[i] SHALL set at the grant edge when requester i is granted, ALUFun[5:4]=00 (ADD/SUB), Sign=1 and the ALU V=1.
REQ-026 When a set and ovf_clear[i] occur in the same cycle, set SHALL win.
REQ-027 ALU V for non-arithmetic functions SHALL pass to rsp_V unfiltered but SHALL NOT affect ovf_sticky.

Reset
REQ-028 With reset=1 at an edge, the block SHALL clear rsp_valid, rsp_Z, rsp_V, rsp_id and ovf_sticky to 0 and set the last-grant pointer to 1 so requester 0 wins the first contention.
REQ-029 req_ready SHALL be 00 during any cycle with reset=1, and an in-flight result SHALL be discarded.

Structure
REQ-030 A shared package SHALL define the ALUFun constants: ADD=000000, SUB=000001, AND=011000, OR=011110, XOR=010110, NOR=010001, SLL=100000, SRL=100001, SRA=100011, EQ=110011, NEQ=110001, LT=110101.
REQ-031 The shared package SHALL define a 2-bit requester-index width constant.
REQ-032 The existing ALU SHALL be the one sub-module; the arbitration and the output register SHALL be local logic.

Verification
REQ-033 The bench SHALL cover: req0 only, ADD A=5 B=7 Sign=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_Z=12, rsp_id=0, rsp_V=0.
REQ-034 The bench SHALL cover: both valid for 4 cycles after reset, rsp_ready=1 -> grants 0,1,0,1 and rsp_id sequence 0,1,0,1.
REQ-035 The bench SHALL cover: req1 SUB A=0x80000000 B=1 Sign=1 -> rsp_V=1, ovf_sticky=10; then ovf_clear=10 -> ovf_sticky=00.
REQ-036 The bench SHALL cover: rsp_ready=0 for 3 cycles with a result held (SLL A=4 B=1 -> rsp_Z=16) -> rsp_Z stable and req_ready=00; rsp_ready=1 with req0 valid -> drain and new grant in the same cycle.
REQ-037 The bench SHALL cover: reset asserted while rsp_valid=1 -> rsp_valid=0 next cycle, and requester 0 wins the next contention.
